// File: rtl/seg_scroll_buffer_pkg.sv
// seg_scroll_buffer_pkg: display codes, step timing and FSM states shared by the scroller
package seg_scroll_buffer_pkg;
  localparam logic [4:0] SEG_BLANK = 5'h1F;
  localparam int SCROLL_FREQ = 12_500_000;  // 0.25 s per step at a 50 MHz board clock
  typedef enum logic [1:0] {IDLE, LOAD, SCROLL} state_e;
endpackage

// File: rtl/seg_scroll_buffer_tick_gen.sv
// tick_gen: one-cycle tick every PERIOD cycles; clr holds the count at zero so the
// first tick after clr drops lands exactly PERIOD cycles later
module tick_gen #(
  parameter int PERIOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int CW = PERIOD > 1 ? $clog2(PERIOD) : 1;
  logic [CW-1:0] cnt_q;
  assign tick = !clr && cnt_q == CW'(PERIOD - 1);
  always_ff @(posedge clk) cnt_q <= (!rst_n || clr || tick) ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/seg_scroll_buffer.sv
// seg_scroll_buffer: buffers a message of 5-bit display codes and scrolls it right-to-left
// across eight digit registers (p7 leftmost, p0 rightmost)
module seg_scroll_buffer
  import seg_scroll_buffer_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int SCROLL_TICKS = SCROLL_FREQ
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [4:0] wr_char,
  input  logic       wr_last,
  input  logic       repeat_en,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic [4:0] p0,
  output logic [4:0] p1,
  output logic [4:0] p2,
  output logic [4:0] p3,
  output logic [4:0] p4,
  output logic [4:0] p5,
  output logic [4:0] p6,
  output logic [4:0] p7
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH + 9);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  state_e        state_q;
  logic [LW-1:0] len_q;
  logic [IW-1:0] idx_q;
  logic          busy_q;
  logic          done_q;
  logic [4:0]    disp_q [8];
  logic [4:0]    mem_q [DEPTH];
  logic          step;
  logic          wr_fire;
  logic          load_end;
  logic          pass_end;
  logic [4:0]    next_char;
  assign wr_ready  = state_q != SCROLL;
  assign wr_fire   = wr_valid & wr_ready;
  // len_q is 0 in IDLE, so this also covers DEPTH == 1 on the first char
  assign load_end  = wr_last || len_q == LW'(DEPTH - 1);
  assign pass_end  = step && idx_q + 1'b1 == IW'(len_q) + IW'(8);
  assign next_char = idx_q < IW'(len_q) ? mem_q[idx_q[AW-1:0]] : SEG_BLANK;
  tick_gen #(.PERIOD(SCROLL_TICKS)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q != SCROLL),
    .tick (step)
  );
  always_ff @(posedge clk)
    if (wr_fire) mem_q[len_q[AW-1:0]] <= wr_char;
  always_ff @(posedge clk) begin
    done_q <= 1'b0;
    if (!rst_n || (abort && state_q != IDLE)) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      for (int i = 0; i < 8; i++) disp_q[i] <= SEG_BLANK;
    end else if (state_q == SCROLL) begin
      if (step) begin
        for (int i = 7; i > 0; i--) disp_q[i] <= disp_q[i-1];
        disp_q[0] <= next_char;
        idx_q     <= pass_end ? '0 : idx_q + 1'b1;
        if (pass_end) begin
          done_q <= 1'b1;
          if (!repeat_en) begin
            state_q <= IDLE;
            len_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
      end
    end else if (wr_fire) begin
      len_q   <= len_q + 1'b1;
      idx_q   <= '0;
      busy_q  <= 1'b1;
      state_q <= load_end ? SCROLL : LOAD;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign p0   = disp_q[0];
  assign p1   = disp_q[1];
  assign p2   = disp_q[2];
  assign p3   = disp_q[3];
  assign p4   = disp_q[4];
  assign p5   = disp_q[5];
  assign p6   = disp_q[6];
  assign p7   = disp_q[7];
endmodule
